// File: rtl/nav_command_sequencer.sv
// Obstacle-avoidance sequencer: synchronizes and debounces three obstacle
// sensors and runs a timed manoeuvre FSM whose one-hot motor commands feed
// the motor controller stage. A retry counter forces a FAULT lockout when
// repeated manoeuvres fail to clear the path.
module nav_command_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PAUSE_CYCLES    = 8,
  parameter int unsigned TURN_CYCLES     = 16,
  parameter int unsigned ROTATE_CYCLES   = 32,
  parameter int unsigned MAX_RETRIES     = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       obs_front_raw,
  input  logic       obs_left_raw,
  input  logic       obs_right_raw,
  output logic       stop_motor,
  output logic       front_motor,
  output logic       turn_left,
  output logic       turn_right,
  output logic       rotate,
  output logic [2:0] state,
  output logic       fault
);

  localparam int unsigned NUM_SENSORS = 3;
  localparam int unsigned DB_W        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned MAX_PT      = (PAUSE_CYCLES > TURN_CYCLES) ? PAUSE_CYCLES : TURN_CYCLES;
  localparam int unsigned MAX_CYC     = (MAX_PT > ROTATE_CYCLES) ? MAX_PT : ROTATE_CYCLES;
  localparam int unsigned TIMER_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned RETRY_W     = $clog2(MAX_RETRIES + 1);

  localparam logic [DB_W-1:0]    DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] PAUSE_LOAD  = TIMER_W'(PAUSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TURN_LOAD   = TIMER_W'(TURN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] ROTATE_LOAD = TIMER_W'(ROTATE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FWD    = 3'd1,
    S_PAUSE  = 3'd2,
    S_TURN_L = 3'd3,
    S_TURN_R = 3'd4,
    S_ROTATE = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  // Sensor bit order: [0]=front, [1]=left, [2]=right
  logic [NUM_SENSORS-1:0] raw;
  logic [NUM_SENSORS-1:0] sync1;
  logic [NUM_SENSORS-1:0] sync2;
  logic [NUM_SENSORS-1:0] filt;

  assign raw = {obs_right_raw, obs_left_raw, obs_front_raw};

  // Two-flop synchronizer for the asynchronous sensor inputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_debounce
    logic [DB_W-1:0] cnt;
    logic            filt_q;

    // Filtered bit follows the synced bit only after a full run of mismatches
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt    <= '0;
        filt_q <= 1'b0;
      end else if (sync2[i] == filt_q) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt    <= '0;
        filt_q <= sync2[i];
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end

    assign filt[i] = filt_q;
  end

  logic front_f;
  logic left_f;
  logic right_f;

  assign front_f = filt[0];
  assign left_f  = filt[1];
  assign right_f = filt[2];

  state_t             state_q;
  state_t             state_d;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;
  logic [RETRY_W-1:0] retry_q;
  logic [RETRY_W-1:0] retry_d;
  logic               timer_done;
  logic [TIMER_W-1:0] timer_dec;
  logic [RETRY_W-1:0] retry_inc;

  assign timer_done = (timer_q == '0);
  assign timer_dec  = timer_done ? timer_q : timer_q - TIMER_W'(1);
  assign retry_inc  = (retry_q == RETRY_MAX) ? retry_q : retry_q + RETRY_W'(1);

  // Next-state, timer and retry bookkeeping; run=0 overrides everything
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    if (!run) begin
      state_d = S_IDLE;
      timer_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_FWD;
          timer_d = '0;
        end
        S_FWD: begin
          if (front_f) begin
            state_d = S_PAUSE;
            timer_d = PAUSE_LOAD;
          end else begin
            retry_d = '0;
          end
        end
        S_PAUSE: begin
          if (!timer_done) begin
            timer_d = timer_dec;
          end else if (retry_q == RETRY_MAX) begin
            state_d = S_FAULT;
            timer_d = '0;
          end else if (!front_f) begin
            state_d = S_FWD;
            timer_d = '0;
          end else if (!right_f) begin
            state_d = S_TURN_R;
            timer_d = TURN_LOAD;
            retry_d = retry_inc;
          end else if (!left_f) begin
            state_d = S_TURN_L;
            timer_d = TURN_LOAD;
            retry_d = retry_inc;
          end else begin
            state_d = S_ROTATE;
            timer_d = ROTATE_LOAD;
            retry_d = retry_inc;
          end
        end
        S_TURN_L, S_TURN_R, S_ROTATE: begin
          if (!timer_done) begin
            timer_d = timer_dec;
          end else if (front_f) begin
            state_d = S_PAUSE;
            timer_d = PAUSE_LOAD;
          end else begin
            state_d = S_FWD;
            timer_d = '0;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  // State register with Moore command outputs registered alongside it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      retry_q     <= '0;
      stop_motor  <= 1'b1;
      front_motor <= 1'b0;
      turn_left   <= 1'b0;
      turn_right  <= 1'b0;
      rotate      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      stop_motor  <= (state_d == S_IDLE) || (state_d == S_PAUSE) || (state_d == S_FAULT);
      front_motor <= (state_d == S_FWD);
      turn_left   <= (state_d == S_TURN_L);
      turn_right  <= (state_d == S_TURN_R);
      rotate      <= (state_d == S_ROTATE);
      fault       <= (state_d == S_FAULT);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_nav_command_sequencer.sv
// Bench for nav_command_sequencer: directed vector table, random stimulus
// against a cycle-level behavioural model, and an asynchronous reset check.
module tb_nav_command_sequencer;

  localparam int DEB  = 4;
  localparam int PAU  = 8;
  localparam int TRN  = 16;
  localparam int ROT  = 32;
  localparam int MAXR = 3;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FWD = 3'd1, ST_PAUSE = 3'd2,
                         ST_TL = 3'd3, ST_TR = 3'd4, ST_ROT = 3'd5, ST_FAULT = 3'd6;
  localparam logic [2:0] OF = 3'b001, OL = 3'b010, OR = 3'b100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       run = 1'b0;
  logic [2:0] obs = 3'b000;
  logic       stop_motor, front_motor, turn_left, turn_right, rotate, fault;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  nav_command_sequencer #(
    .DEBOUNCE_CYCLES(DEB), .PAUSE_CYCLES(PAU), .TURN_CYCLES(TRN),
    .ROTATE_CYCLES(ROT), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .run(run),
    .obs_front_raw(obs[0]), .obs_left_raw(obs[1]), .obs_right_raw(obs[2]),
    .stop_motor(stop_motor), .front_motor(front_motor), .turn_left(turn_left),
    .turn_right(turn_right), .rotate(rotate), .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  // Command pattern {stop, front, left, right, rotate} for a state code
  function automatic logic [4:0] cmd_of(input logic [2:0] st);
    case (st)
      ST_FWD:  return 5'b01000;
      ST_TL:   return 5'b00100;
      ST_TR:   return 5'b00010;
      ST_ROT:  return 5'b00001;
      default: return 5'b10000;
    endcase
  endfunction

  function automatic logic [8:0] expect_of(input logic [2:0] st);
    return {st, (st == ST_FAULT), cmd_of(st)};
  endfunction

  function automatic logic [8:0] dut_bundle();
    return {state, fault, stop_motor, front_motor, turn_left, turn_right, rotate};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got state/fault/cmd=%0d/%b/%b required %0d/%b/%b",
               name, $time, act[8:6], act[5], act[4:0], exp[8:6], exp[5], exp[4:0]);
    end
  endtask

  // Behavioural model: sensor pipeline, mismatch run length, mode with cycles remaining
  int         m_mode = 0;
  int         m_remain = 0;
  int         m_retries = 0;
  logic [2:0] m_s1 = '0, m_s2 = '0, m_filt = '0;
  int         m_mis [3] = '{0, 0, 0};

  task automatic model_reset();
    m_mode = 0; m_remain = 0; m_retries = 0;
    m_s1 = '0; m_s2 = '0; m_filt = '0;
    for (int i = 0; i < 3; i++) m_mis[i] = 0;
  endtask

  task automatic enter_timed(input int mode, input int len);
    m_mode = mode;
    m_remain = len;
  endtask

  task automatic model_step();
    logic ff, fl, fr;
    ff = m_filt[0]; fl = m_filt[1]; fr = m_filt[2];
    if (!run) begin
      m_mode = 0; m_remain = 0; m_retries = 0;
    end else begin
      case (m_mode)
        0: m_mode = 1;
        1: if (ff) enter_timed(2, PAU); else m_retries = 0;
        2: if (m_remain > 1) m_remain--;
           else if (m_retries == MAXR) m_mode = 6;
           else if (!ff) m_mode = 1;
           else begin
             if (!fr) enter_timed(4, TRN);
             else if (!fl) enter_timed(3, TRN);
             else enter_timed(5, ROT);
             m_retries = (m_retries + 1 > MAXR) ? MAXR : m_retries + 1;
           end
        3, 4, 5: if (m_remain > 1) m_remain--;
                 else if (ff) enter_timed(2, PAU);
                 else m_mode = 1;
        default: ;
      endcase
    end
    for (int i = 0; i < 3; i++) begin
      if (m_s2[i] != m_filt[i]) begin
        m_mis[i]++;
        if (m_mis[i] == DEB) begin
          m_filt[i] = m_s2[i];
          m_mis[i] = 0;
        end
      end else begin
        m_mis[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = obs;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  // Every cycle: compare against the model and require one-hot commands
  always @(negedge clk) begin
    if (chk_en) begin
      check("model", dut_bundle(), expect_of(3'(m_mode)));
      vectors++;
      if (!$onehot({stop_motor, front_motor, turn_left, turn_right, rotate})) begin
        miscompares++;
        $display("FAIL onehot @%0t: cmd=%b required exactly one bit set", $time,
                 {stop_motor, front_motor, turn_left, turn_right, rotate});
      end
    end
  end

  typedef struct {
    logic       run;
    logic [2:0] obs;
    int         cycles;
    logic [2:0] exp_state;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [2:0] o, input int n, input logic [2:0] st);
    vec_t v;
    v.run = r; v.obs = o; v.cycles = n; v.exp_state = st;
    vecs.push_back(v);
  endfunction

  task automatic blocked_cycle(input logic [2:0] o, input logic [2:0] man, input int len);
    add(1, o, 1, ST_PAUSE);
    add(1, o, PAU - 1, ST_PAUSE);
    add(1, o, 1, man);
    add(1, o, len - 1, man);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset", dut_bundle(), expect_of(ST_IDLE));
    reset_n = 1'b1;

    // Start, glitch rejection, debounce latency, turn-left choice
    add(1, 3'b000, 1, ST_FWD);
    add(1, OF, 3, ST_FWD);
    add(1, 3'b000, 5, ST_FWD);
    add(1, OF, 6, ST_FWD);
    add(1, OF, 1, ST_PAUSE);
    add(1, OF | OR, PAU - 1, ST_PAUSE);
    add(1, OF | OR, 1, ST_TL);
    add(1, OR, TRN - 1, ST_TL);
    add(1, OR, 1, ST_FWD);
    // Fully blocked: three rotates then fault, run=0 releases
    add(1, 3'b111, 6, ST_FWD);
    add(1, 3'b111, 1, ST_PAUSE);
    add(1, 3'b111, PAU - 1, ST_PAUSE);
    add(1, 3'b111, 1, ST_ROT);
    add(1, 3'b111, ROT - 1, ST_ROT);
    blocked_cycle(3'b111, ST_ROT, ROT);
    blocked_cycle(3'b111, ST_ROT, ROT);
    add(1, 3'b111, 1, ST_PAUSE);
    add(1, 3'b111, PAU - 1, ST_PAUSE);
    add(1, 3'b111, 1, ST_FAULT);
    add(1, 3'b111, 5, ST_FAULT);
    add(0, 3'b111, 1, ST_IDLE);
    add(0, 3'b000, 8, ST_IDLE);
    add(1, 3'b000, 3, ST_FWD);
    // Retry counter restarts after a clear FWD cycle
    add(1, OF | OL, 6, ST_FWD);
    add(1, OF | OL, 1, ST_PAUSE);
    add(1, OF | OL, PAU - 1, ST_PAUSE);
    add(1, OF | OL, 1, ST_TR);
    add(1, OF | OL, TRN - 1, ST_TR);
    blocked_cycle(OF | OL, ST_TR, TRN);
    add(1, OF | OL, 1, ST_PAUSE);
    add(1, OF | OL, PAU - 1, ST_PAUSE);
    add(1, OF | OL, 1, ST_TR);
    add(1, 3'b000, TRN - 1, ST_TR);
    add(1, 3'b000, 1, ST_FWD);
    add(1, 3'b000, 2, ST_FWD);
    add(1, OF | OL, 6, ST_FWD);
    add(1, OF | OL, 1, ST_PAUSE);
    add(1, OF | OL, PAU - 1, ST_PAUSE);
    add(1, OF | OL, 1, ST_TR);
    // run=0 on cycle 5 of a right turn
    add(1, OF | OL, 4, ST_TR);
    add(0, OF | OL, 1, ST_IDLE);

    foreach (vecs[i]) begin
      run = vecs[i].run;
      obs = vecs[i].obs;
      repeat (vecs[i].cycles) @(negedge clk);
      check($sformatf("vec%0d", i), dut_bundle(), expect_of(vecs[i].exp_state));
    end

    // Random stimulus, checked every cycle against the model
    for (int blk = 0; blk < 220; blk++) begin
      int len;
      run = ($urandom_range(0, 24) != 0);
      obs = 3'($urandom_range(0, 7));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 40);
      repeat (len) @(negedge clk);
    end

    // Asynchronous reset mid-cycle, then restart
    run = 1'b0;
    obs = 3'b000;
    repeat (2) @(negedge clk);
    run = 1'b1;
    repeat (20) @(negedge clk);
    check("pre_reset", dut_bundle(), expect_of(ST_FWD));
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check("async_reset", dut_bundle(), expect_of(ST_IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("restart", dut_bundle(), expect_of(ST_FWD));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
